// File: rtl/uart_frame_pkg.sv
// Shared types and default constants for the UART frame loader.
// The CHECK state exists only when UART_FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

  localparam int         DEF_IMG_PIXELS  = 784;
  localparam logic [7:0] DEF_HDR_BYTE    = 8'hAA;
  localparam int         DEF_TIMEOUT_CYC = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef UART_FRAME_CHECKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_READY = 2'd3
  } state_e;

endpackage

// File: rtl/uart_frame_loader_pix_ram.sv
// Simple dual-port pixel buffer: one synchronous write port, one registered read port.
module pix_ram #(
  parameter int DEPTH = 784,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Collects a header-prefixed pixel frame from a UART byte stream into a buffer.
// Define UART_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int         IMG_PIXELS  = DEF_IMG_PIXELS,
  parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int        AW          = $clog2(IMG_PIXELS),
  localparam int        GW          = $clog2(TIMEOUT_CYC)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          rx_done,
  input  logic [7:0]    rx_byte,
  input  logic [AW-1:0] pix_rd_addr,
  output logic [7:0]    pix_rd_data,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic          frame_err,
  output logic          busy
);

  state_e        state, state_nxt;
  logic [AW-1:0] wr_addr, wr_addr_nxt;
  logic [GW-1:0] gap, gap_nxt;
  logic          err_nxt;
  logic          wr_en;
  logic          gap_hit;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    xor_acc, xor_nxt;
`endif

  assign gap_hit = (gap == GW'(TIMEOUT_CYC - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    gap_nxt     = gap;
    err_nxt     = 1'b0;
    wr_en       = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    xor_nxt     = xor_acc;
`endif
    unique case (state)
      ST_IDLE: begin
        if (rx_done && rx_byte == HDR_BYTE) begin
          state_nxt   = ST_LOAD;
          wr_addr_nxt = '0;
          gap_nxt     = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          xor_nxt     = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (rx_done) begin
          wr_en   = 1'b1;
          gap_nxt = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          xor_nxt = xor_acc ^ rx_byte;
`endif
          if (wr_addr == AW'(IMG_PIXELS - 1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_nxt = ST_CHECK;
`else
            state_nxt = ST_READY;
`endif
          end else begin
            wr_addr_nxt = wr_addr + 1'b1;
          end
        end else if (gap_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_done) begin
          gap_nxt = '0;
          if (rx_byte == xor_acc) begin
            state_nxt = ST_READY;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (gap_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
`endif
      ST_READY: begin
        if (frame_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      wr_addr   <= '0;
      gap       <= '0;
      frame_err <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      xor_acc   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      wr_addr   <= wr_addr_nxt;
      gap       <= gap_nxt;
      frame_err <= err_nxt;
`ifdef UART_FRAME_CHECKSUM_EN
      xor_acc   <= xor_nxt;
`endif
    end
  end

  assign frame_ready = (state == ST_READY);
`ifdef UART_FRAME_CHECKSUM_EN
  assign busy = (state == ST_LOAD) || (state == ST_CHECK);
`else
  assign busy = (state == ST_LOAD);
`endif

  pix_ram #(.DEPTH(IMG_PIXELS), .AW(AW)) u_pix_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rx_byte),
    .rd_addr (pix_rd_addr),
    .rd_data (pix_rd_data)
  );

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized self-checking bench for uart_frame_loader against a frame-level reference model.
module tb_uart_frame_loader;

  localparam int         IMG = 784;
  localparam logic [7:0] HDR = 8'hAA;
  localparam int         TO  = 40;
  localparam int         AW  = $clog2(IMG);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic [AW-1:0] pix_rd_addr;
  logic [7:0]    pix_rd_data;
  logic          frame_ready;
  logic          frame_ack;
  logic          frame_err;
  logic          busy;

  uart_frame_loader #(.IMG_PIXELS(IMG), .HDR_BYTE(HDR), .TIMEOUT_CYC(TO)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .pix_rd_addr (pix_rd_addr),
    .pix_rd_data (pix_rd_data),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int errs     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what phase of a frame the stream is in and what the image holds.
  typedef enum int {MD_IDLE, MD_FILL, MD_SUM, MD_HOLD} mode_e;
  mode_e      m_mode;
  logic [7:0] m_img [IMG];
  int         m_cnt;
  logic [7:0] m_sum;
  int         m_quiet;
  bit         m_err;
  bit         m_rd_ok;
  logic [7:0] m_rd;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_mode = MD_IDLE; m_cnt = 0; m_sum = 8'h00; m_quiet = 0; m_err = 0; m_rd_ok = 0;
    end else begin
      m_rd_ok = (m_mode == MD_HOLD);
      m_rd    = m_img[pix_rd_addr];
      m_err   = 0;
      case (m_mode)
        MD_IDLE: if (rx_done && rx_byte == HDR) begin
          m_mode = MD_FILL; m_cnt = 0; m_sum = 8'h00; m_quiet = 0;
        end
        MD_FILL, MD_SUM: begin
          if (rx_done) begin
            m_quiet = 0;
            if (m_mode == MD_FILL) begin
              m_img[m_cnt] = rx_byte;
              m_sum ^= rx_byte;
              m_cnt++;
              if (m_cnt == IMG) m_mode = CK ? MD_SUM : MD_HOLD;
            end else if (rx_byte == m_sum) begin
              m_mode = MD_HOLD;
            end else begin
              m_err = 1; m_mode = MD_IDLE;
            end
          end else begin
            m_quiet++;
            if (m_quiet == TO) begin m_err = 1; m_mode = MD_IDLE; end
          end
        end
        MD_HOLD: if (frame_ack) m_mode = MD_IDLE;
        default: m_mode = MD_IDLE;
      endcase
    end
  end

  always @(negedge sys_clk) begin
    check("busy", busy, (m_mode == MD_FILL) || (m_mode == MD_SUM));
    check("frame_ready", frame_ready, m_mode == MD_HOLD);
    check("frame_err", frame_err, m_err);
    if (m_mode == MD_HOLD && m_rd_ok) check("pix_rd_data", pix_rd_data, m_rd);
    if (frame_err) errs++;
  end

  bit         hold_addr = 1'b0;
  bit         ack_noise = 1'b0;
  logic [7:0] tx [IMG];

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (!hold_addr) pix_rd_addr = AW'($urandom_range(0, IMG - 1));
    frame_ack = ack_noise && ($urandom_range(0, 15) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_byte = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic send_frame(input int n, input bit with_ck, input bit bad_ck, input bit rgap);
    logic [7:0] cks;
    cks = 8'h00;
    ack_noise = 1'b1;
    send_byte(HDR, 0);
    for (int i = 0; i < n; i++) begin
      cks ^= tx[i];
      send_byte(tx[i], rgap ? $urandom_range(0, 3) : 0);
    end
    if (with_ck) send_byte(cks ^ {7'd0, bad_ck}, rgap ? $urandom_range(0, 3) : 0);
    ack_noise = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!frame_ready && k < 50) begin step(); k++; end
    check("ready_wait", frame_ready, 1'b1);
  endtask

  task automatic read_at(input string name, input int a, input logic [7:0] exp);
    hold_addr   = 1'b1;
    pix_rd_addr = AW'(a);
    step();
    check(name, pix_rd_data, exp);
    hold_addr   = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    check("ack_clears_ready", frame_ready, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    sys_rst = 1'b1; rx_done = 1'b0; rx_byte = 8'h00; frame_ack = 1'b0; pix_rd_addr = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", frame_ready, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_rd", pix_rd_data, 8'h00);
    sys_rst = 1'b0;
    step();

    // Noise byte, then a counting frame.
    send_byte(8'h11, 0);
    for (int i = 0; i < IMG; i++) tx[i] = 8'(i % 256);
    send_frame(IMG, CK, 1'b0, 1'b0);
    wait_ready();
    check("model_xor", m_sum, 8'h00);
    read_at("rd_addr5", 5, 8'h05);
    read_at("rd_addr783", 783, 8'h0F);
    ack();

    // All-ones frame: wrong checksum when enabled, plain load otherwise.
    for (int i = 0; i < IMG; i++) tx[i] = 8'h01;
    e0 = errs;
`ifdef UART_FRAME_CHECKSUM_EN
    send_frame(IMG, 1'b1, 1'b1, 1'b0);
    repeat (2) step();
    check("cksum_err_pulses", errs - e0, 1);
    check("cksum_ready", frame_ready, 1'b0);
    check("cksum_busy", busy, 1'b0);
`else
    send_frame(IMG, 1'b0, 1'b0, 1'b0);
    wait_ready();
    read_at("ones_addr0", 0, 8'h01);
    check("ones_no_err", errs - e0, 0);
    ack();
`endif

    // Partial frame followed by silence.
    for (int i = 0; i < IMG; i++) tx[i] = 8'($urandom);
    e0 = errs;
    send_frame(100, 1'b0, 1'b0, 1'b1);
    repeat (TO + 5) step();
    check("timeout_pulses", errs - e0, 1);
    check("timeout_busy", busy, 1'b0);

    // Extra bytes while READY leave the buffer alone.
    for (int i = 0; i < IMG; i++) tx[i] = 8'((i * 7) % 256);
    send_frame(IMG, CK, 1'b0, 1'b1);
    wait_ready();
    for (int i = 0; i < 10; i++) send_byte(8'hEE, 0);
    read_at("ready_addr10", 10, 8'h46);
    check("ready_held", frame_ready, 1'b1);
    ack();
    send_byte(HDR, 0);
    check("new_hdr_busy", busy, 1'b1);

    // Reset at pixel 400 of the frame that was just started.
    e0 = errs;
    for (int i = 0; i < 400; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    sys_rst = 1'b1;
    #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", frame_ready, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    check("midrst_rd", pix_rd_data, 8'h00);
    step();
    sys_rst = 1'b0;
    step();
    check("midrst_no_err", errs - e0, 0);
    for (int i = 0; i < IMG; i++) tx[i] = 8'(i % 256);
    send_frame(IMG, CK, 1'b0, 1'b1);
    wait_ready();
    read_at("post_rst_addr5", 5, 8'h05);
    read_at("post_rst_addr400", 400, 8'h90);
    ack();

    // A byte arriving exactly on the gap terminal count is kept.
    for (int i = 0; i < IMG; i++) tx[i] = 8'($urandom);
    tx[50] = 8'h5A;
    e0 = errs;
    send_byte(HDR, 0);
    for (int i = 0; i < 50; i++) send_byte(tx[i], 0);
    send_byte(tx[50], TO - 1);
    begin
      logic [7:0] cks;
      cks = 8'h00;
      for (int i = 0; i < IMG; i++) cks ^= tx[i];
      for (int i = 51; i < IMG; i++) send_byte(tx[i], $urandom_range(0, 3));
      if (CK) send_byte(cks, TO - 1);
    end
    wait_ready();
    check("terminal_no_err", errs - e0, 0);
    read_at("terminal_addr50", 50, 8'h5A);
    ack();

    // Random frames, random gaps, random checksum corruption.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < IMG; i++) tx[i] = 8'($urandom);
      for (int j = 0; j < 3; j++) send_byte((8'($urandom) == HDR) ? 8'h11 : 8'($urandom), 1);
      send_frame(IMG, CK, CK && ($urandom_range(0, 1) == 1), 1'b1);
      repeat (5) step();
      if (frame_ready) ack();
    end
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
